// File: rtl/fsm_pkg.sv
// Shared definitions for the pass-sequencing engine and its round-robin scheduler.
// State encodings match the engine so the mirror can be compared directly.
package fsm_pkg;

    typedef enum logic [3:0] {
        M_S1 = 4'd8,
        M_S2 = 4'd1,
        M_S3 = 4'd3,
        M_S4 = 4'd4,
        M_S5 = 4'd5,
        M_S6 = 4'd7
    } mstate_e;

    localparam int OUT_LONG_DEF  = 10;
    localparam int OUT_SHORT_DEF = 5;

    // S1 branches on enable: long pass via S2/S3, short pass straight to S4.
    function automatic mstate_e next_state(input mstate_e s, input logic en);
        mstate_e n;
        case (s)
            M_S1:    n = en ? M_S2 : M_S4;
            M_S2:    n = M_S3;
            M_S3:    n = M_S4;
            M_S4:    n = M_S5;
            M_S5:    n = M_S6;
            default: n = M_S1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/fsm.sv
// Pass-sequencing engine: long pass S1..S6 when enabled in S1, short pass S1,S4,S5,S6 otherwise.
// out reports the pass type in S1 and is zero in every other state.
module fsm
    import fsm_pkg::*;
#(
    parameter int OUT_W     = 4,
    parameter int OUT_LONG  = OUT_LONG_DEF,
    parameter int OUT_SHORT = OUT_SHORT_DEF
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             enable,
    output logic [OUT_W-1:0] out
);

    mstate_e state_q;
    mstate_e state_d;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= M_S1;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = next_state(state_q, enable);
        out     = '0;
        if (state_q == M_S1) begin
            out = enable ? OUT_W'(OUT_LONG) : OUT_W'(OUT_SHORT);
        end
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping around.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int             cand;
        logic [IDX_W-1:0] cand_idx;
        idx      = '0;
        valid    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        // Walk from the farthest offset down so the nearest request is written last.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand     = (int'(ptr) + i) % N_REQ;
            cand_idx = cand[IDX_W-1:0];
            if (req[cand_idx]) begin
                idx   = cand_idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fsm_rr_sched.sv
// Round-robin scheduler that hands each long engine pass to one requester,
// tracking the engine in a local mirror and flagging any disagreement with eng_out.
module fsm_rr_sched
    import fsm_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int OUT_W     = 4,
    parameter int OUT_LONG  = OUT_LONG_DEF,
    parameter int OUT_SHORT = OUT_SHORT_DEF,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic [N_REQ-1:0]           req,
    input  logic [OUT_W-1:0]           eng_out,
    input  logic                       err_clr,
    output logic                       eng_enable,
    output logic [N_REQ-1:0]           gnt,
    output logic [$clog2(N_REQ)-1:0]   gnt_id,
    output logic [N_REQ-1:0]           done,
    output logic                       busy,
    output logic [CNT_W-1:0]           pass_cnt,
    output logic                       sync_err
);

    localparam int IDX_W = $clog2(N_REQ);

    mstate_e            state_q;
    mstate_e            state_d;
    logic [IDX_W-1:0]   ptr_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [IDX_W-1:0]   gnt_id_q;
    logic               busy_q;
    logic [CNT_W-1:0]   pass_cnt_q;
    logic               sync_err_q;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [N_REQ-1:0]   pick_onehot;
    logic [OUT_W-1:0]   exp_out;
    logic               sync_mis;
    logic               arb_cycle;
    logic               pass_end;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Enable comes only from registered state and req, so eng_out never loops back into it.
    assign eng_enable = (state_q == M_S1) & (|req);
    assign arb_cycle  = (state_q == M_S1) & pick_valid;
    assign pass_end   = (state_q == M_S6) & busy_q;

    always_comb begin
        state_d     = next_state(state_q, eng_enable);
        pick_onehot = '0;
        pick_onehot[pick_idx] = 1'b1;
        exp_out     = '0;
        if (state_q == M_S1) begin
            exp_out = eng_enable ? OUT_W'(OUT_LONG) : OUT_W'(OUT_SHORT);
        end
        sync_mis    = (eng_out != exp_out);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= M_S1;
            ptr_q      <= '0;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            busy_q     <= 1'b0;
            pass_cnt_q <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (arb_cycle) begin
                gnt_q    <= pick_onehot;
                gnt_id_q <= pick_idx;
                busy_q   <= 1'b1;
                ptr_q    <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            end else if (pass_end) begin
                gnt_q  <= '0;
                busy_q <= 1'b0;
                if (pass_cnt_q != '1) begin
                    pass_cnt_q <= pass_cnt_q + 1'b1;
                end
            end
            // A fresh mismatch outranks a simultaneous clear.
            if (sync_mis) begin
                sync_err_q <= 1'b1;
            end else if (err_clr) begin
                sync_err_q <= 1'b0;
            end
        end
    end

    assign gnt      = gnt_q;
    assign gnt_id   = gnt_id_q;
    assign done     = pass_end ? gnt_q : '0;
    assign busy     = busy_q;
    assign pass_cnt = pass_cnt_q;
    assign sync_err = sync_err_q;

endmodule

// File: doc/fsm_rr_sched.md
Name: fsm_rr_sched

Overview:
- Round-robin scheduler that shares one pass-sequencing engine (`fsm`) among N_REQ requesters.
- The engine has one 4-bit output. When its enable is high in S1 it runs a long pass, S1→S2→S3→S4→S5→S6→S1, which is 6 cycles. When enable is low in S1 it runs a short pass, S1→S4→S5→S6→S1, which is 4 cycles.
- This block drives the engine's `enable` and grants each long pass to exactly one requester.
- It tracks the engine's state in a local mirror and checks the mirror against the engine's `out` each cycle.
- Sits between the requester clients and the engine instance, at the same hierarchy level as the engine.

Parameters:
- N_REQ, 4, number of requesters, range 2..16.
- OUT_W, 4, width of the engine's out bus.
- OUT_LONG, 10, engine out value in S1 when enable=1.
- OUT_SHORT, 5, engine out value in S1 when enable=0.
- CNT_W, 16, width of the long-pass counter.

Ports:
- clk, input, 1, single clock for the block.
- rstb, input, 1, asynchronous active-low reset. Must be the same net that resets the engine.
- req, input, N_REQ, level request per requester. Held until its done pulse.
- eng_out, input, OUT_W, the engine's out.
- err_clr, input, 1, synchronous clear of sync_err.
- eng_enable, output, 1, drives the engine's enable.
- gnt, output, N_REQ, one-hot grant. All zero when no long pass is owned.
- gnt_id, output, clog2(N_REQ), index of the current or most recent winner.
- done, output, N_REQ, one-cycle pulse in the last cycle of the owner's pass.
- busy, output, 1, high while a long pass is in progress.
- pass_cnt, output, CNT_W, number of completed long passes. Saturates at all-ones.
- sync_err, output, 1, sticky flag: the mirror and eng_out disagreed.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rstb.
- Reset values:
  - Mirror state = M_S1, pointer = 0.
  - gnt = 0, gnt_id = 0, done = 0, busy = 0, pass_cnt = 0, sync_err = 0.
  - The engine resets to S1 on the same edge, so the mirror and the engine start aligned.
- Mirror FSM: states M_S1..M_S6 plus a 1-bit long flag. Transitions match the engine exactly:
  - M_S1 → M_S2 if eng_enable, else M_S1 → M_S4.
  - M_S2 → M_S3 → M_S4 → M_S5 → M_S6 → M_S1.
- eng_enable:
  - Combinational, equal to (mirror == M_S1) & |req.
  - Zero in every other state.
  - Depends only on registered state and req, never on eng_out, so there is no combinational loop.
- Arbitration (only in M_S1 with |req):
  - Winner = first set bit of req, searching from the pointer upward with wrap-around.
  - On the next edge: gnt <= onehot(winner), gnt_id <= winner, busy <= 1, pointer <= (winner+1) mod N_REQ.
  - gnt is high in mirror states M_S2..M_S6: 5 cycles, starting the cycle after the arbitration cycle.
- Pass completion:
  - In M_S6 with busy: done[gnt_id] = 1 for that cycle.
  - On the next edge: gnt <= 0, busy <= 0, pass_cnt increments unless it is saturated.
- Arbitration cycles at rate: back-to-back long passes put an M_S1 arbitration cycle between grants. Steady-state period is 6 cycles per grant.
- Idle: when no req is high in M_S1, a short pass runs (4 cycles). gnt stays 0 and the next arbitration is 4 cycles later.
- req dropped during a grant: the pass is not aborted. gnt, done and the pass_cnt increment all still occur.
- req rising mid-pass: not seen until the next M_S1.
- Worst-case wait from req assertion to gnt: (N_REQ−1)×6 + 6 + 1 cycles.
- Sync check, every cycle:
  - In M_S1, eng_out must equal OUT_LONG if eng_enable is high, otherwise OUT_SHORT.
  - In other states, eng_out must be 0.
  - A mismatch sets sync_err on the next edge. It stays set until err_clr or reset.
  - err_clr in the same cycle as a new mismatch: set wins.
  - The mirror does not resynchronise to the engine; sync_err is diagnostic only.
- Reset mid-pass: all state returns to reset values immediately. No done is issued for the interrupted pass.

Decomposition:
- Package fsm_pkg holds:
  - the mirror state enum with the same encodings as the engine: S1=8, S2=1, S3=3, S4=4, S5=5, S6=7;
  - OUT_LONG and OUT_SHORT defaults.
- One sub-module, rr_pick: combinational round-robin priority picker. Inputs are req and pointer; outputs are winner index and a valid flag. It is reused by later arbiters.
- The top level holds the mirror FSM, grant/done registers, counter and checker.
- The bench instantiates fsm_rr_sched together with a real `fsm` instance.

Test Plan:
1. Only req[2]=1 held, with the engine attached.
   - Required: eng_enable=1 in the first M_S1 cycle; gnt=4'b0100 for 5 cycles.
   - Required: done[2] in the 5th of those cycles, then pass_cnt=1 and gnt_id=2.
2. req=4'b1111 held.
   - Required: grants in order 0,1,2,3,0, one grant every 6 cycles.
   - Required: pointer wraps 3→0; pass_cnt=5 after 30 cycles.
   - Required: sync_err stays 0 throughout.
3. req=0 for 12 cycles, then req[1]=1.
   - Required: three short passes with eng_enable=0, gnt=0 and eng_out=5 at each M_S1.
   - Required: the grant to requester 1 starts in the cycle after the next M_S1.
4. req[0] dropped in the 2nd grant cycle.
   - Required: gnt=1 holds through M_S6 and done[0] pulses.
   - Required: the next M_S1 takes the short pass if no other req is present.
5. Force eng_out=3 during M_S3.
   - Required: sync_err=1 on the next cycle and it stays 1.
   - Required: err_clr=1 clears it one cycle later.
6. Assert rstb=0 during grant cycle 3 with req=4'b0011.
   - Required: gnt, busy and done go to 0 immediately and pass_cnt is unchanged at 0.
   - Required: after release, requester 0 wins first (pointer=0).
